// File: rtl/fifo_nibble_packer.sv
// fifo_nibble_packer: drains a nibble FIFO and packs entries LSB-first
// into words presented on a valid/ready port, with flush for partials.
module fifo_nibble_packer #(
  parameter int DATA_W  = 4,
  parameter int NIBBLES = 4,
  parameter int CNT_W   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           empty,
  output logic                           read_en,
  input  logic [DATA_W-1:0]              read_data,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W*NIBBLES-1:0]      out_word,
  output logic [$clog2(NIBBLES+1)-1:0]   out_count,
  output logic [CNT_W-1:0]               word_cnt
);

  localparam int CW = $clog2(NIBBLES+1);
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     c;
  logic              f;
  logic              flush_pend;
  logic [DATA_W-1:0] slot [NIBBLES];
  logic [CW:0]       occ;
  logic              room;
  logic              full_cap;
  logic              flush_go;
  logic              accept;

  // occupancy counts the read still in flight so we never over-issue
  assign occ      = {1'b0, c} + {{CW{1'b0}}, f};
  assign room     = occ < (CW+1)'(NIBBLES);
  assign full_cap = f && (c == CW'(NIBBLES-1));
  assign flush_go = flush_pend && !f && (c != '0);
  assign accept   = (state == HOLD) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FILL: if (full_cap || flush_go) state_nx = HOLD;
      HOLD: if (out_ready) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    read_en   = 1'b0;
    unique case (state)
      FILL: read_en = room;
      HOLD: begin
        out_valid = 1'b1;
        read_en   = out_ready && !f;
      end
      default: read_en = 1'b0;
    endcase
    read_en = read_en && !rst && !empty && !flush_pend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c          <= '0;
      f          <= 1'b0;
      flush_pend <= 1'b0;
      out_count  <= '0;
      word_cnt   <= '0;
      for (int k = 0; k < NIBBLES; k++) slot[k] <= '0;
    end else begin
      f <= read_en;
      if (accept) begin
        c          <= '0;
        flush_pend <= 1'b0;
        out_count  <= '0;
        word_cnt   <= word_cnt + CNT_W'(1);
        for (int k = 0; k < NIBBLES; k++) slot[k] <= '0;
      end else begin
        if (f) begin
          slot[c[IW-1:0]] <= read_data;
          c               <= c + CW'(1);
        end
        if (state == FILL && flush && (c != '0 || f))
          flush_pend <= 1'b1;
        if (state == FILL && full_cap)
          out_count <= CW'(NIBBLES);
        else if (state == FILL && flush_go)
          out_count <= c;
      end
    end
  end

  always_comb begin
    out_word = '0;
    for (int k = 0; k < NIBBLES; k++)
      out_word[k*DATA_W +: DATA_W] = slot[k];
  end

endmodule
